// File: rtl/numeric_pkg.sv
// Shared numeric constants and state encoding for the alpha settle/capture path.
// alpha values are Q5.15 reciprocals of the bisection root (ONE_Q = 1.0).
package numeric_pkg;

    localparam int ALPHA_W = 20;
    localparam int Q_FRAC  = 15;
    localparam int ONE_Q   = 32768;

    localparam int DEF_TOL        = 1;
    localparam int DEF_SETTLE_CNT = 4;
    localparam int DEF_TIMEOUT    = 64;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_TRACK = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/alpha_absdiff.sv
// Unsigned |a - b| on W-bit operands with a W+1-bit result.
// Purely combinational; shared by convergence checkers.
module alpha_absdiff #(
    parameter int W = 20
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W:0]   d
);

    logic [W:0] a_x;
    logic [W:0] b_x;

    assign a_x = {1'b0, a};
    assign b_x = {1'b0, b};
    assign d   = (a_x >= b_x) ? (a_x - b_x) : (b_x - a_x);

endmodule

// File: rtl/alpha_settle_capture.sv
// Tracks bisection alpha after each restart, captures on settle or timeout.
// Build option ALPHA_AVG_EN: capture the mean of the last two samples.
module alpha_settle_capture
    import numeric_pkg::*;
#(
    parameter int W          = ALPHA_W,
    parameter int TOL        = DEF_TOL,
    parameter int SETTLE_CNT = DEF_SETTLE_CNT,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] alpha_in,
    input  logic         restart,
    output logic [W-1:0] alpha_out,
    output logic         alpha_valid,
    input  logic         alpha_ready,
    output logic         timeout_flag,
    output logic [7:0]   iter_count
);

    localparam logic [W:0] TOL_V = (W+1)'(TOL);
    localparam logic [7:0] SET_V = 8'(SETTLE_CNT);
    localparam logic [7:0] TMO_V = 8'(TIMEOUT);

    logic [1:0]   state_q;
    logic [W-1:0] prev_q;
    logic [7:0]   stable_q;
    logic [7:0]   iter_q;
    logic [W-1:0] out_q;
    logic         valid_q;
    logic         tflag_q;

    logic [W:0]   diff;
    logic         is_stable;
    logic [7:0]   stable_nxt;
    logic [7:0]   iter_nxt;
    logic         conv;
    logic         tmo;
    logic [W-1:0] cap;

    alpha_absdiff #(.W(W)) u_absdiff (
        .a (alpha_in),
        .b (prev_q),
        .d (diff)
    );

    assign is_stable  = (diff <= TOL_V);
    assign stable_nxt = is_stable ? stable_q + 8'd1 : 8'd0;
    assign iter_nxt   = sat_inc8(iter_q);
    assign conv       = is_stable && (stable_nxt == SET_V);
    assign tmo        = (iter_nxt == TMO_V);

`ifdef ALPHA_AVG_EN
    logic [W:0] pair_sum;
    // Truncating mean hides the one-LSB dither of the bisection output.
    assign pair_sum = {1'b0, alpha_in} + {1'b0, prev_q};
    assign cap      = pair_sum[W:1];
`else
    assign cap = alpha_in;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            prev_q   <= '0;
            stable_q <= '0;
            iter_q   <= '0;
            out_q    <= '0;
            valid_q  <= 1'b0;
            tflag_q  <= 1'b0;
        end else if (restart) begin
            // Restart wins in every state; an unaccepted result is dropped.
            state_q  <= ST_TRACK;
            prev_q   <= alpha_in;
            stable_q <= '0;
            iter_q   <= '0;
            valid_q  <= 1'b0;
            tflag_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_q <= ST_IDLE;
                end
                ST_TRACK: begin
                    prev_q   <= alpha_in;
                    iter_q   <= iter_nxt;
                    stable_q <= stable_nxt;
                    if (conv || tmo) begin
                        out_q   <= cap;
                        valid_q <= 1'b1;
                        tflag_q <= !conv;
                        state_q <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (alpha_ready) begin
                        valid_q <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign alpha_out    = out_q;
    assign alpha_valid  = valid_q;
    assign timeout_flag = tflag_q;
    assign iter_count   = iter_q;

endmodule

// File: tb/tb_alpha_settle_capture.sv
// Directed bench for alpha_settle_capture: settle, timeout, hold, restart.
// Expected capture values follow the ALPHA_AVG_EN build option.
module tb_alpha_settle_capture;

    localparam int W = 20;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] alpha_in;
    logic         restart;
    logic [W-1:0] alpha_out;
    logic         alpha_valid;
    logic         alpha_ready;
    logic         timeout_flag;
    logic [7:0]   iter_count;

    int n_checks = 0;
    int n_fail   = 0;

    alpha_settle_capture dut (
        .clk          (clk),
        .reset        (reset),
        .alpha_in     (alpha_in),
        .restart      (restart),
        .alpha_out    (alpha_out),
        .alpha_valid  (alpha_valid),
        .alpha_ready  (alpha_ready),
        .timeout_flag (timeout_flag),
        .iter_count   (iter_count)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    logic [W-1:0] exp_alt1;
    logic [W-1:0] exp_tmo;

    initial begin
`ifdef ALPHA_AVG_EN
        exp_alt1 = 20'h08000;
        exp_tmo  = 20'h08001;
`else
        exp_alt1 = 20'h08001;
        exp_tmo  = 20'h08002;
`endif
        reset       = 1'b0;
        alpha_in    = 20'h08000;
        restart     = 1'b0;
        alpha_ready = 1'b0;

        // reset held with restart toggling
        for (int i = 0; i < 6; i++) begin
            restart = ~restart;
            tick();
        end
        check("rst_valid", 32'(alpha_valid), 32'd0);
        check("rst_out", 32'(alpha_out), 32'd0);
        check("rst_tflag", 32'(timeout_flag), 32'd0);
        check("rst_iter", 32'(iter_count), 32'd0);
        restart = 1'b0;
        reset   = 1'b1;
        tick(6);
        check("idle_novalid", 32'(alpha_valid), 32'd0);
        check("idle_iter", 32'(iter_count), 32'd0);

        // constant input settles in exactly SETTLE_CNT cycles
        restart = 1'b1;
        tick();
        restart     = 1'b0;
        alpha_ready = 1'b1;
        tick(3);
        check("const_early", 32'(alpha_valid), 32'd0);
        check("const_iter3", 32'(iter_count), 32'd3);
        tick();
        check("const_valid", 32'(alpha_valid), 32'd1);
        check("const_out", 32'(alpha_out), 32'h08000);
        check("const_tflag", 32'(timeout_flag), 32'd0);
        check("const_iter", 32'(iter_count), 32'd4);
        tick();
        check("const_accept", 32'(alpha_valid), 32'd0);

        // one-LSB dither still converges
        alpha_in = 20'h08001;
        restart  = 1'b1;
        tick();
        restart = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            alpha_in = (i % 2 == 1) ? 20'h08000 : 20'h08001;
            tick();
        end
        check("alt1_valid", 32'(alpha_valid), 32'd1);
        check("alt1_out", 32'(alpha_out), 32'(exp_alt1));
        check("alt1_tflag", 32'(timeout_flag), 32'd0);
        check("alt1_iter", 32'(iter_count), 32'd4);
        tick();
        check("alt1_accept", 32'(alpha_valid), 32'd0);

        // two-LSB swing never settles -> timeout
        alpha_in = 20'h08002;
        restart  = 1'b1;
        tick();
        restart = 1'b0;
        for (int i = 1; i <= 63; i++) begin
            alpha_in = (i % 2 == 1) ? 20'h08000 : 20'h08002;
            tick();
        end
        check("tmo_early", 32'(alpha_valid), 32'd0);
        check("tmo_iter63", 32'(iter_count), 32'd63);
        alpha_in = 20'h08002;
        tick();
        check("tmo_valid", 32'(alpha_valid), 32'd1);
        check("tmo_flag", 32'(timeout_flag), 32'd1);
        check("tmo_iter", 32'(iter_count), 32'd64);
        check("tmo_out", 32'(alpha_out), 32'(exp_tmo));
        tick();
        check("tmo_accept", 32'(alpha_valid), 32'd0);
        check("tmo_flag_hold", 32'(timeout_flag), 32'd1);

        // HOLD freezes outputs while consumer stalls
        alpha_ready = 1'b0;
        alpha_in    = 20'h12345;
        restart     = 1'b1;
        tick();
        restart = 1'b0;
        tick(4);
        check("hold_valid", 32'(alpha_valid), 32'd1);
        for (int i = 1; i <= 10; i++) begin
            alpha_in = 20'(20'h12345 + 20'(i * 7));
            tick();
        end
        check("hold_out", 32'(alpha_out), 32'h12345);
        check("hold_still", 32'(alpha_valid), 32'd1);
        check("hold_iter", 32'(iter_count), 32'd4);
        alpha_ready = 1'b1;
        tick();
        check("hold_accept", 32'(alpha_valid), 32'd0);
        alpha_ready = 1'b0;
        tick(5);
        check("hold_idle", 32'(alpha_valid), 32'd0);

        // restart inside HOLD drops result and re-tracks
        alpha_in = 20'h00100;
        restart  = 1'b1;
        tick();
        restart = 1'b0;
        tick(4);
        check("hr_valid", 32'(alpha_valid), 32'd1);
        alpha_in = 20'h00200;
        restart  = 1'b1;
        tick();
        restart = 1'b0;
        check("hr_drop", 32'(alpha_valid), 32'd0);
        check("hr_iter0", 32'(iter_count), 32'd0);
        tick(3);
        check("hr_early", 32'(alpha_valid), 32'd0);
        tick();
        check("hr_valid2", 32'(alpha_valid), 32'd1);
        check("hr_out2", 32'(alpha_out), 32'h00200);
        restart     = 1'b1;
        alpha_ready = 1'b1;
        tick();
        restart     = 1'b0;
        alpha_ready = 1'b0;
        check("hrr_accept", 32'(alpha_valid), 32'd0);
        tick(4);
        check("hrr_track", 32'(alpha_valid), 32'd1);
        check("hrr_iter", 32'(iter_count), 32'd4);
        alpha_ready = 1'b1;
        tick();
        check("hrr_done", 32'(alpha_valid), 32'd0);

        // restart in TRACK re-arms the counters
        alpha_in = 20'h00300;
        restart  = 1'b1;
        tick();
        restart = 1'b0;
        tick(2);
        restart = 1'b1;
        tick();
        restart = 1'b0;
        check("tr_iter0", 32'(iter_count), 32'd0);
        tick(3);
        check("tr_early", 32'(alpha_valid), 32'd0);
        tick();
        check("tr_valid", 32'(alpha_valid), 32'd1);
        check("tr_iter", 32'(iter_count), 32'd4);
        tick();

        // async reset aborts a pending result
        alpha_ready = 1'b0;
        alpha_in    = 20'h00400;
        restart     = 1'b1;
        tick();
        restart = 1'b0;
        tick(4);
        check("ar_valid", 32'(alpha_valid), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("ar_valid0", 32'(alpha_valid), 32'd0);
        check("ar_out0", 32'(alpha_out), 32'd0);
        check("ar_iter0", 32'(iter_count), 32'd0);
        tick();
        reset = 1'b1;
        tick(3);
        check("ar_idle", 32'(alpha_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
